// File: rtl/lifo_stack.sv
// Hardware LIFO stack with registered top-of-stack, full/empty/count status.
// Ports: clk, resetN (sync, active-low), push, pop, data_in, data_out, full,
// empty, count; with `define STACK_ERR_EN also overflow, underflow, err_clr.
module lifo_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
`ifdef STACK_ERR_EN
  ,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
`endif
);

  localparam logic [AW:0] SP_ONE = (AW+1)'(1);
  localparam logic [AW:0] SP_TWO = (AW+1)'(2);
  localparam logic [AW:0] SP_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      sp;
  logic [AW:0]      sp_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  // Entry that becomes the new top after a pop.
  assign rd_idx = AW'(sp - SP_TWO);
  assign count  = sp;

  always_comb begin
    sp_nxt   = sp;
    dout_nxt = data_out;
    wr_en    = 1'b0;
    wr_idx   = AW'(sp);
    case ({push, pop})
      2'b10: begin
        if (!full) begin
          wr_en    = 1'b1;
          sp_nxt   = sp + SP_ONE;
          dout_nxt = data_in;
        end
      end
      2'b01: begin
        if (!empty) begin
          sp_nxt   = sp - SP_ONE;
          dout_nxt = (sp >= SP_TWO) ? mem[rd_idx] : '0;
        end
      end
      2'b11: begin
        // Replace top; on an empty stack this degenerates to a push.
        wr_en    = 1'b1;
        dout_nxt = data_in;
        if (empty) sp_nxt = sp + SP_ONE;
        else       wr_idx = AW'(sp - SP_ONE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      sp       <= '0;
      data_out <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      sp       <= sp_nxt;
      data_out <= dout_nxt;
      full     <= (sp_nxt == SP_MAX);
      empty    <= (sp_nxt == '0);
    end
  end

  // Storage is not reset; sp alone defines what is valid.
  always_ff @(posedge clk) begin
    if (resetN && wr_en) mem[wr_idx] <= data_in;
  end

`ifdef STACK_ERR_EN
  logic ovf_set;
  logic unf_set;

  assign ovf_set = push & ~pop & full;
  assign unf_set = pop & empty;

  // A new error in the same edge as err_clr leaves the flag set.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow & ~err_clr) | ovf_set;
      underflow <= (underflow & ~err_clr) | unf_set;
    end
  end
`endif

endmodule

// File: doc/lifo_stack.md
# lifo_stack

- Hardware LIFO responder at the far end of the processor's stack interface.
- Accepts single-cycle push/pop strobes and always presents the current top-of-stack on a registered output, so the processor can sample a value in the same cycle its pop strobe is high.
- Drives full/empty/count status back to the processor.
- Sits beside the processor and RAM in the lab top level; the processor's stack_data_out feeds data_in and its stack_data_in is fed by data_out.

## Interface
- WIDTH, 8, data word width
- DEPTH, 16, number of entries; power of two, ≥2
- AW, 4, pointer width, log2(DEPTH)

- clk  input  1  clock
- resetN  input  1  reset, synchronous, active-low
- push  input  1  write data_in onto the stack this cycle
- pop  input  1  remove top entry this cycle
- data_in  input  WIDTH  word to push
- data_out  output  WIDTH  registered top-of-stack; 0 when empty
- full  output  1  registered; count == DEPTH
- empty  output  1  registered; count == 0
- count  output  AW+1  registered number of stored entries
- overflow  output  1  sticky; push attempted while full (only with STACK_ERR_EN)
- underflow  output  1  sticky; pop attempted while empty (only with STACK_ERR_EN)
- err_clr  input  1  clears overflow/underflow (only with STACK_ERR_EN)

## Operation
- Storage: DEPTH×WIDTH register array mem.
- Stack pointer sp (AW+1 bits) equals count and points to the next free slot.
- data_out is a register mirror of mem[sp-1], not a combinational array read.
- Per rising edge, resetN high, decoded on {push, pop}:
  - 00: hold everything.
  - 10, not full: mem[sp] ← data_in; sp ← sp+1; data_out ← data_in.
  - 10, full: ignored; state unchanged; overflow set.
  - 01, not empty: sp ← sp-1; data_out ← mem[sp-2] if sp ≥ 2, else 0.
  - 01, empty: ignored; data_out stays 0; underflow set.
  - 11, not empty (including full): replace top. mem[sp-1] ← data_in; data_out ← data_in; sp unchanged; no error.
  - 11, empty: behaves as push (one entry stored, data_out ← data_in); underflow set.
- full/empty/count are recomputed from the next sp and registered in the same edge as the operation.
- Contents of mem are not cleared by reset; only sp and the outputs are.
- No arithmetic wrap: sp is saturated by the full/empty guards and never exceeds DEPTH or goes below 0.

## Timing
- Reset (resetN low at an edge): sp=0, data_out=0, empty=1, full=0, count=0, overflow=0, underflow=0.
- Reset overrides any simultaneous push/pop. Reset in the middle of a sequence discards the stack.
- Push latency is 1 cycle: the value strobed at edge N appears on data_out after edge N; full/count also update after edge N.
- Pop contract: the processor raises pop for one cycle and samples data_out at the edge that ends that cycle. That edge still samples the pre-pop top; the new top is visible after it.
- Back-to-back pops on consecutive cycles each return successive entries with no bubble.
- Back-to-back pushes on consecutive cycles each store, until full.
- Strobes are level-sampled every edge. A strobe held for k cycles performs k operations.
- Status is never combinational from push/pop. The requester must not push when full or pop when empty; doing so is defined as above but loses the operation.

## Configuration
- STACK_ERR_EN defined:
  - overflow, underflow and err_clr ports exist.
  - Error flags set on the edge of the offending strobe and hold until err_clr or reset.
  - If err_clr and a new error occur in the same edge, the flag ends set (set wins).
- STACK_ERR_EN undefined:
  - The three ports and their flip-flops are absent.
  - Illegal operations are silently ignored, with identical data/status behaviour.

## Test plan
- Reset then idle: after resetN low for 1 edge → data_out=0x00, empty=1, full=0, count=0; stays so for 5 idle cycles.
- Push 0x11, 0x22, 0x33 on consecutive cycles → data_out 0x11, 0x22, 0x33 after each edge; count=3. Then 3 consecutive pops → values sampled at the pop edges are 0x33, 0x22, 0x11; afterwards data_out=0x00, empty=1.
- Push 16 values 0x40..0x4F → full=1, count=16, data_out=0x4F. A 17th push of 0x99 → state unchanged, overflow=1 (ERR_EN). err_clr → overflow=0.
- Pop when empty → data_out=0x00, count=0, underflow=1. Push+pop of 0x5A while empty → count=1, data_out=0x5A, underflow=1.
- Push 0x01, 0x02, then push+pop of 0x77 → count=2, data_out=0x77. Pop → data_out=0x01.
- Push 0xA1, 0xA2, then assert resetN low on the same edge as a pop → count=0, data_out=0x00, empty=1. Next push 0x05 → data_out=0x05, count=1.
